// File: rtl/omsp_spm_key_loader_pkg.sv
// Shared definitions for the SPM key-write path: loader state encoding and
// key geometry helpers also used by omsp_spm_control.
package omsp_spm_key_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_WRITE,
        ST_FLUSH,
        ST_DONE,
        ST_ERROR
    } spm_kl_state_e;

    // Number of 16-bit words in a key of the given width.
    function automatic int nwords(input int security);
        return security / 16;
    endfunction

    // Width of the key word index bus.
    function automatic int key_idx_size(input int security);
        return $clog2(security / 16 + 1);
    endfunction

endpackage

// File: rtl/omsp_spm_key_loader.sv
// Writer side of the SPM key-write interface: streams a crypto-derived key into
// the SPM control array one 16-bit word at a time, aborting on select loss or violation.
module omsp_spm_key_loader
    import omsp_spm_key_loader_pkg::*;
#(
    parameter int SECURITY     = 64,
    parameter int KEY_IDX_SIZE = key_idx_size(SECURITY)
) (
    input  logic                    mclk,
    input  logic                    puc_rst,
    input  logic                    start,
    input  logic [15:0]             target_id,
    input  logic                    word_valid,
    input  logic [15:0]             word_data,
    output logic                    word_ready,
    output logic [15:0]             spm_key_select,
    input  logic                    spm_key_select_valid,
    input  logic                    violation,
    output logic                    write_key,
    output logic [15:0]             key_in,
    output logic [KEY_IDX_SIZE-1:0] key_idx,
    output logic                    busy,
    output logic                    done,
    output logic                    error
);

    localparam int                      NWORDS   = nwords(SECURITY);
    localparam logic [KEY_IDX_SIZE-1:0] LAST_IDX = KEY_IDX_SIZE'(NWORDS - 1);

    spm_kl_state_e           state;
    spm_kl_state_e           next_state;
    logic [KEY_IDX_SIZE-1:0] word_cnt;
    logic                    in_seq;
    logic                    abort;
    logic                    accept;

    // The DONE/ERROR pulse cycles count as idle so busy covers only the active sequence.
    assign in_seq     = (state == ST_SELECT) || (state == ST_WRITE) || (state == ST_FLUSH);
    assign abort      = in_seq && (violation || !spm_key_select_valid);
    assign word_ready = (state == ST_WRITE);
    assign accept     = word_ready && word_valid;
    assign busy       = in_seq;
    assign done       = (state == ST_DONE);
    assign error      = (state == ST_ERROR);

    always_comb begin
        // NOTE: next_state gets a default first so no path through the case infers a latch.
        next_state = state;
        case (state)
            ST_IDLE:   if (start) next_state = ST_SELECT;
            ST_SELECT: next_state = abort ? ST_ERROR : ST_WRITE;
            ST_WRITE: begin
                if (abort)
                    next_state = ST_ERROR;
                else if (accept && (word_cnt == LAST_IDX))
                    next_state = ST_FLUSH;
            end
            ST_FLUSH:  next_state = abort ? ST_ERROR : ST_DONE;
            ST_DONE:   next_state = ST_IDLE;
            ST_ERROR:  next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            spm_key_select <= 16'h0000;
            word_cnt       <= '0;
            write_key      <= 1'b0;
            key_in         <= 16'h0000;
            key_idx        <= '0;
        end else begin
            write_key <= 1'b0;

            if ((state == ST_IDLE) && start)
                spm_key_select <= target_id;
            else if ((next_state == ST_DONE) || (next_state == ST_ERROR))
                spm_key_select <= 16'h0000;

            if (state == ST_SELECT)
                word_cnt <= '0;

            // A word taken in an abort cycle is dropped; key_in/key_idx keep their last value.
            if (accept && !abort) begin
                write_key <= 1'b1;
                key_in    <= word_data;
                key_idx   <= word_cnt;
                if (word_cnt != LAST_IDX)
                    word_cnt <= word_cnt + 1'b1;
            end
        end
    end

endmodule
